dsp_mul_arbiter: RTL and testbench
==================================

Name: dsp_mul_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one pipelined dsp_multiplier-class datapath (fixed latency, one issue per cycle) among N_REQ requesters.
- Accepts operand pairs over valid/ready, issues them to the multiplier and tags each issue with its requester ID. Routes each returning product to the issuing requester's response register.
- HLS-style ap_start/ap_idle/ap_ready/ap_done control. Sits between kernel compute lanes and the single shared DSP multiplier on the Alveo U50 build.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, operand and product width
- MUL_LATENCY, 3, cycles from mul_in_valid to mul_out_valid of the shared multiplier

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  level; arbitration enabled while high
- ap_idle  out  1  high in IDLE state
- ap_ready  out  1  high in RUN state
- ap_done  out  1  one-cycle pulse on DRAIN->IDLE
- req_valid  in  N_REQ  per-requester operand valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_x  in  N_REQ*DATA_WIDTH  flattened operand x; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_y  in  N_REQ*DATA_WIDTH  flattened operand y
- resp_valid  out  N_REQ  per-requester product valid
- resp_ready  in  N_REQ  per-requester product accept
- resp_product  out  N_REQ*DATA_WIDTH  flattened per-requester product
- mul_in_valid  out  1  issue strobe to multiplier
- mul_x, mul_y  out  DATA_WIDTH  issued operands (registered)
- mul_out_valid  in  1  multiplier result strobe
- mul_product  in  DATA_WIDTH  multiplier result
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, ap_rst_n=0): state IDLE; ap_idle=1, ap_ready=0, ap_done=0, req_ready=0, resp_valid=0, resp_product=0, mul_in_valid=0, mul_x=mul_y=0, err=0; RR pointer=0; tag pipeline, outstanding bits cleared. The multiplier shares ap_rst_n, so in-flight work is discarded.
- FSM:
  - IDLE->RUN when ap_start=1.
  - RUN->DRAIN when ap_start=0.
  - DRAIN->IDLE, pulsing ap_done for 1 cycle, when the tag pipeline is empty and all resp_valid=0.
  - DRAIN->RUN when ap_start=1 again, with no ap_done pulse.
- Eligibility: requester i is eligible when state=RUN, req_valid[i]=1 and outstanding[i]=0. Each requester may have at most one operation in flight or unconsumed.
- Grant: combinational round-robin among eligible requesters, searching from the RR pointer upward with wrap. req_ready is one-hot on the granted requester and 0 otherwise.
- On accept (req_valid&req_ready at cycle T):
  - set outstanding[i];
  - RR pointer <- i+1 mod N_REQ (pointer unchanged when nothing is accepted);
  - at T+1: mul_in_valid=1, mul_x/mul_y=operands, tag {valid,i} enters a MUL_LATENCY-deep shift register.
- Return: at T+1+MUL_LATENCY, mul_out_valid pairs with the tag at the shift-register tail. resp_product[i]<=mul_product and resp_valid[i]=1 at T+2+MUL_LATENCY. Minimum request-to-response latency is MUL_LATENCY+2.
- Response: resp_valid[i] and resp_product[i] are held until resp_ready[i]. On that handshake, resp_valid[i] and outstanding[i] clear. Requester i becomes eligible again in the next cycle; a same-cycle regrant is not allowed.
- Throughput: one issue per cycle across distinct requesters. A single requester gets one op per MUL_LATENCY+3 cycles.
- Width: product passed through at DATA_WIDTH bits (low half of the full product); no arithmetic in this block.
- err: set and held until reset when mul_out_valid differs from the tail tag valid in any cycle.
- Simultaneous ap_start fall and accept: the accept in that cycle completes normally; no further grants.
- resp_ready is ignored while resp_valid=0.

Optional Feature:
- DSP_ARB_STATS_EN defined: adds outputs stat_issues (32b, count of accepts) and stat_conflicts (32b, count of cycles with ≥2 eligible requesters). Both wrap at 2^32, reset to 0, and clear on the IDLE->RUN transition.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dsp_arb_pkg holds:
  - state encoding constants (ST_IDLE=0, ST_RUN=1, ST_DRAIN=2);
  - the tag width function clog2(N_REQ);
  - default MUL_LATENCY.
- One natural sub-module: rr_arbiter (eligible vector + pointer -> one-hot grant and grant index), purely combinational, reused elsewhere.

Test Plan:
- Single op: N_REQ=4, ap_start=1, requester 2 sends x=7, y=6 -> mul_in_valid 1 cycle later with 7/6; resp_valid[2] with 42 at accept+5; ap_done pulse after ap_start drop and resp consumed.
- Fairness: all 4 requesters hold req_valid with resp_ready=1 -> grant order 0,1,2,3,0,...; no requester starved; mul_in_valid back-to-back for 4 cycles.
- Backpressure: requester 1 resp_ready=0 for 20 cycles -> resp_valid[1] and product stable; req_ready[1]=0 throughout while others keep issuing.
- Drain: drop ap_start with 3 ops in flight -> no new req_ready; all 3 responses delivered; ap_done exactly once; ap_idle=1 afterwards.
- Reset mid-operation: assert ap_rst_n=0 with 2 ops in flight -> all outputs at reset values immediately; no resp_valid after release; err=0.
- Protocol error: inject mul_out_valid=1 with empty tag pipeline -> err=1 next cycle and held until reset.

Source files
------------

// File: rtl/dsp_mul_arbiter_pkg.sv
// Shared types and constants for the DSP multiplier arbiter.
// State encoding, tag width helper and default multiplier latency.
package dsp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_MUL_LATENCY = 3;

  function automatic int tag_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dsp_mul_arbiter_if.sv
// Requester, response and shared-multiplier signal bundle.
// slave = arbiter side, master = lanes plus multiplier side.
interface dsp_mul_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_x;
  logic [N_REQ*DATA_WIDTH-1:0] req_y;

  logic [N_REQ-1:0]            resp_valid;
  logic [N_REQ-1:0]            resp_ready;
  logic [N_REQ*DATA_WIDTH-1:0] resp_product;

  logic                        mul_in_valid;
  logic [DATA_WIDTH-1:0]       mul_x;
  logic [DATA_WIDTH-1:0]       mul_y;
  logic                        mul_out_valid;
  logic [DATA_WIDTH-1:0]       mul_product;

  modport slave (
    input  req_valid, req_x, req_y,
    input  resp_ready,
    input  mul_out_valid, mul_product,
    output req_ready,
    output resp_valid, resp_product,
    output mul_in_valid, mul_x, mul_y
  );

  modport master (
    output req_valid, req_x, req_y,
    output resp_ready,
    output mul_out_valid, mul_product,
    input  req_ready,
    input  resp_valid, resp_product,
    input  mul_in_valid, mul_x, mul_y
  );

endinterface

// File: rtl/dsp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search upward from ptr_i
// with wrap, return one-hot grant and its index.
module rr_arbiter
  import dsp_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int TW    = tag_width(N_REQ)
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [TW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [TW-1:0]    idx_o,
  output logic             any_o
);

  logic [TW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = TW'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && elig_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined multiplier among N_REQ lanes.
// Define DSP_ARB_STATS_EN to add stat_issues/stat_conflicts counters.
module dsp_mul_arbiter
  import dsp_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic ap_start,
  output logic ap_idle,
  output logic ap_ready,
  output logic ap_done,
  dsp_mul_arbiter_if.slave bus,
`ifdef DSP_ARB_STATS_EN
  output logic [31:0] stat_issues,
  output logic [31:0] stat_conflicts,
`endif
  output logic err
);

  localparam int TW = tag_width(N_REQ);
  localparam int DW = DATA_WIDTH;

  typedef struct packed {
    logic          v;
    logic [TW-1:0] id;
  } tag_t;

  state_e state_q;
  logic   idle_q;
  logic   ready_q;
  logic   done_q;

  logic [N_REQ-1:0] out_q;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [TW-1:0]    gidx;
  logic             gany;
  logic [TW-1:0]    ptr_q;
  logic [TW-1:0]    ptr_d;

  logic [N_REQ-1:0][DW-1:0] rx;
  logic [N_REQ-1:0][DW-1:0] ry;

  tag_t                      iss_q;
  tag_t [MUL_LATENCY-1:0]    sr_q;
  tag_t                      tail;
  logic                      pipe_empty;

  logic                      mul_v_q;
  logic [DW-1:0]             mul_x_q;
  logic [DW-1:0]             mul_y_q;

  logic [N_REQ-1:0]          resp_v_q;
  logic [N_REQ-1:0][DW-1:0]  resp_p_q;
  logic                      err_q;

  assign rx = bus.req_x;
  assign ry = bus.req_y;

  // A lane with an op in flight or an unconsumed product is not eligible.
  assign elig = (state_q == ST_RUN) ? (bus.req_valid & ~out_q) : '0;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (gany)
  );

  assign ptr_d = (gidx == TW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

  assign tail = sr_q[MUL_LATENCY-1];

  always_comb begin
    pipe_empty = !iss_q.v;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      if (sr_q[k].v) pipe_empty = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (ap_start) begin
            state_q <= ST_RUN;
            idle_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!ap_start) begin
            state_q <= ST_DRAIN;
            ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (ap_start) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else if (pipe_empty && !(|resp_v_q)) begin
            state_q <= ST_IDLE;
            idle_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idle_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Issue register plus tag delay line matching the multiplier latency.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q   <= '0;
      mul_v_q <= 1'b0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      iss_q   <= '0;
      sr_q    <= '0;
    end else begin
      mul_v_q  <= gany;
      iss_q.v  <= gany;
      iss_q.id <= gidx;
      sr_q[0]  <= iss_q;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
      if (gany) begin
        ptr_q   <= ptr_d;
        mul_x_q <= rx[gidx];
        mul_y_q <= ry[gidx];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_q    <= '0;
      resp_v_q <= '0;
      resp_p_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (resp_v_q[i] && bus.resp_ready[i]) begin
          resp_v_q[i] <= 1'b0;
          out_q[i]    <= 1'b0;
        end
      end
      if (gany) out_q[gidx] <= 1'b1;
      if (bus.mul_out_valid && tail.v) begin
        resp_v_q[tail.id] <= 1'b1;
        resp_p_q[tail.id] <= bus.mul_product;
      end
      if (bus.mul_out_valid != tail.v) err_q <= 1'b1;
    end
  end

`ifdef DSP_ARB_STATS_EN
  logic [31:0] iss_cnt_q;
  logic [31:0] conf_cnt_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      iss_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else if (state_q == ST_IDLE && ap_start) begin
      iss_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (gany) iss_cnt_q <= iss_cnt_q + 32'd1;
      if ($countones(elig) >= 2) conf_cnt_q <= conf_cnt_q + 32'd1;
    end
  end

  assign stat_issues    = iss_cnt_q;
  assign stat_conflicts = conf_cnt_q;
`endif

  assign ap_idle          = idle_q;
  assign ap_ready         = ready_q;
  assign ap_done          = done_q;
  assign bus.req_ready    = gnt;
  assign bus.resp_valid   = resp_v_q;
  assign bus.resp_product = resp_p_q;
  assign bus.mul_in_valid = mul_v_q;
  assign bus.mul_x        = mul_x_q;
  assign bus.mul_y        = mul_y_q;
  assign err              = err_q;

endmodule

// File: tb/tb_dsp_mul_arbiter.sv
// Directed bench for dsp_mul_arbiter with a 3-stage multiplier model.
// Vector table for single ops, hand sequences for multi-cycle cases.
module tb_dsp_mul_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ap_start = 1'b0;
  logic ap_idle, ap_ready, ap_done, err;
`ifdef DSP_ARB_STATS_EN
  logic [31:0] st_iss, st_conf;
`endif

  dsp_mul_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  always #5 clk = ~clk;

  dsp_mul_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MUL_LATENCY(L)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .ap_start (ap_start),
    .ap_idle  (ap_idle),
    .ap_ready (ap_ready),
    .ap_done  (ap_done),
    .bus      (bus),
`ifdef DSP_ARB_STATS_EN
    .stat_issues    (st_iss),
    .stat_conflicts (st_conf),
`endif
    .err      (err)
  );

  logic [L-1:0]  pv;
  logic [DW-1:0] pp [L];
  logic          inject = 1'b0;
  logic [N-1:0][DW-1:0] tx, ty;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < L; k++) pp[k] <= '0;
    end else begin
      pv    <= {pv[L-2:0], bus.mul_in_valid};
      pp[0] <= DW'(bus.mul_x * bus.mul_y);
      for (int k = 1; k < L; k++) pp[k] <= pp[k-1];
    end
  end

  assign bus.mul_out_valid = pv[L-1] | inject;
  assign bus.mul_product   = pp[L-1];
  assign bus.req_x         = tx;
  assign bus.req_y         = ty;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    int          r;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] p;
  } vec_t;

  vec_t vt [4];

  int   gseq [$];
  int   gcyc [$];
  logic [N-1:0] g;
  int   mvcnt, bad1h, got1, rdy1_bad, held_bad, other, seen_v;
  int   ng, bad_rdy, dones, nresp, rv, ev;
  logic [31:0] p1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2, 32'd7, 32'd6, 32'd42};
    vt[1] = '{0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
    vt[2] = '{1, 32'h0001_0000, 32'h0001_0000, 32'h0};
    vt[3] = '{3, 32'd123, 32'd1000, 32'd123000};

    bus.req_valid  = '0;
    bus.resp_ready = '0;
    tx = '0;
    ty = '0;

    #12;
    chk("rst_ctrl", {ap_idle, ap_ready, ap_done, err}, 4'b1000);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_prod", |bus.resp_product, 0);
    chk("rst_mul", {bus.mul_in_valid, bus.mul_x}, 0);
    chk("rst_mul_y", bus.mul_y, 0);

    @(negedge clk);
    rst_n = 1'b1;
    step();
    ap_start = 1'b1;
    step();
    #1;
    chk("run_ctrl", {ap_idle, ap_ready}, 2'b01);

    for (int v = 0; v < 4; v++) begin
      int r, lat;
      r = vt[v].r;
      tx[r] = vt[v].x;
      ty[r] = vt[v].y;
      bus.req_valid = 4'(1 << r);
      #1;
      chk($sformatf("v%0d_req_ready", v), bus.req_ready, 64'(1 << r));
      step();
      bus.req_valid = '0;
      #1;
      chk($sformatf("v%0d_mul_in_valid", v), bus.mul_in_valid, 1);
      chk($sformatf("v%0d_mul_x", v), bus.mul_x, vt[v].x);
      chk($sformatf("v%0d_mul_y", v), bus.mul_y, vt[v].y);
      lat = 1;
      while (!bus.resp_valid[r] && lat < 20) begin
        step();
        lat++;
      end
      chk($sformatf("v%0d_latency", v), lat, 5);
      chk($sformatf("v%0d_product", v), bus.resp_product[r*DW +: DW], vt[v].p);
      bus.resp_ready[r] = 1'b1;
      step();
      bus.resp_ready = '0;
      #1;
      chk($sformatf("v%0d_resp_clear", v), bus.resp_valid[r], 0);
    end

    // Fairness: all lanes busy, responses consumed immediately.
    for (int i = 0; i < N; i++) begin
      tx[i] = 32'(i + 1);
      ty[i] = 32'd10;
    end
    bus.resp_ready = '1;
    bus.req_valid  = '1;
    #1;
    mvcnt = 0;
    bad1h = 0;
    for (int c = 0; c < 16; c++) begin
      if ($countones(bus.req_ready) > 1) bad1h++;
      if (bus.req_ready != 0) begin
        gseq.push_back($clog2(bus.req_ready));
        gcyc.push_back(c);
      end
      if (c >= 1 && c <= 4 && bus.mul_in_valid) mvcnt++;
      for (int i = 0; i < N; i++) begin
        if (bus.resp_valid[i])
          chk($sformatf("fair_prod%0d", i), bus.resp_product[i*DW +: DW],
              64'((i + 1) * 10));
      end
      step();
      #1;
    end
    chk("fair_onehot", bad1h, 0);
    chk("fair_ngrants", gseq.size(), 12);
    if (gseq.size() >= 8) begin
      for (int k = 0; k < 8; k++)
        chk($sformatf("fair_order%0d", k), gseq[k], k % 4);
      chk("fair_b2b_span", gcyc[3] - gcyc[0], 3);
    end
    chk("fair_mul_b2b", mvcnt, 4);
    bus.req_valid = '0;
    repeat (8) step();
    #1;

    // Backpressure on lane 1.
    bus.resp_ready = 4'b1101;
    bus.req_valid  = '1;
    #1;
    got1 = 0; rdy1_bad = 0; held_bad = 0; other = 0; seen_v = 0; p1 = '0;
    for (int c = 0; c < 30; c++) begin
      if (got1 != 0 && bus.req_ready[1]) rdy1_bad++;
      if (bus.req_ready[1]) got1 = 1;
      if (bus.req_ready != 0 && !bus.req_ready[1]) other++;
      if (seen_v != 0) begin
        if (!bus.resp_valid[1] || bus.resp_product[DW +: DW] !== p1) held_bad++;
      end else if (bus.resp_valid[1]) begin
        seen_v = 1;
        p1 = bus.resp_product[DW +: DW];
      end
      step();
      #1;
    end
    chk("bp_lane1_granted", got1, 1);
    chk("bp_no_regrant", rdy1_bad, 0);
    chk("bp_resp_seen", seen_v, 1);
    chk("bp_resp_held", held_bad, 0);
    chk("bp_resp_value", p1, 20);
    chk("bp_others_issue", other >= 12, 1);
    bus.resp_ready = '1;
    bus.req_valid  = '0;
    repeat (8) step();
    #1;

    // Drain: three in flight, ap_start drops with the third accept.
    bus.resp_ready = '0;
    bus.req_valid  = 4'b0111;
    #1;
    ng = 0;
    for (int c = 0; c < 12 && ng < 3; c++) begin
      g = bus.req_ready;
      if (g != 0) begin
        ng++;
        if (ng == 3) ap_start = 1'b0;
      end
      step();
      bus.req_valid = bus.req_valid & ~g;
      #1;
    end
    chk("drain_issued", ng, 3);
    chk("drain_ready_low", ap_ready, 0);
    bus.req_valid = 4'b1000;
    #1;
    bad_rdy = 0; dones = 0; nresp = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus.req_ready != 0) bad_rdy++;
      if (ap_done) dones++;
      if (c == 8) bus.resp_ready = '1;
      nresp += $countones(bus.resp_valid & bus.resp_ready);
      step();
      #1;
    end
    chk("drain_no_grant", bad_rdy, 0);
    chk("drain_resps", nresp, 3);
    chk("drain_done_once", dones, 1);
    chk("drain_idle", {ap_idle, ap_ready}, 2'b10);
    bus.req_valid  = '0;
    bus.resp_ready = '0;

    // Reset with two ops in flight.
    ap_start = 1'b1;
    step();
    bus.req_valid = 4'b0011;
    step();
    step();
    bus.req_valid = '0;
    #1;
    rst_n    = 1'b0;
    ap_start = 1'b0;
    #1;
    chk("mrst_ctrl", {ap_idle, ap_ready, ap_done, err}, 4'b1000);
    chk("mrst_req_ready", bus.req_ready, 0);
    chk("mrst_resp_valid", bus.resp_valid, 0);
    chk("mrst_mul", {bus.mul_in_valid, bus.mul_x}, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    rv = 0;
    ev = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.resp_valid != 0) rv++;
      if (err) ev++;
    end
    chk("mrst_no_resp", rv, 0);
    chk("mrst_no_err", ev, 0);

    // Protocol error: result strobe with empty tag pipeline.
    #1;
    chk("perr_pre", err, 0);
    inject = 1'b1;
    step();
    inject = 1'b0;
    #1;
    chk("perr_set", err, 1);
    repeat (5) step();
    chk("perr_held", err, 1);
    rst_n = 1'b0;
    #1;
    chk("perr_rst", err, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
